hhmm_display_scan: RTL and testbench



---
 rtl/disp_pkg.sv | 35 +++
 rtl/bcd_to_seg.sv | 23 ++
 rtl/hhmm_display_scan.sv | 151 +++++++++++++++
 tb/tb_hhmm_display_scan.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants and types for the HH:MM 7-segment scan display.
//   SEG_BLANK  - all segments off (active-low bus {g,f,e,d,c,b,a})
//   SEG_DASH   - only segment g lit, shown for non-BCD digit values
//   DIGIT_SEG  - active-low patterns for digits 0..9 (entry N = digit N)
//   dig_idx_e  - scan slot index, also the anode bit number of each digit
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Packed so entry 9 is the leftmost element of the literal.
    localparam logic [9:0][6:0] DIGIT_SEG = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef enum logic [1:0] {
        DIG_MIN_ONES = 2'd0,
        DIG_MIN_TENS = 2'd1,
        DIG_HR_ONES  = 2'd2,
        DIG_HR_TENS  = 2'd3
    } dig_idx_e;

endpackage

// File: rtl/bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Combinational BCD digit to active-low 7-segment pattern. Values above 9
// decode to a dash so a corrupted upstream counter is visible on the display.
// Ports:
//   bcd  in  [3:0]  BCD digit
//   seg  out [6:0]  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg = DIGIT_SEG[bcd];
        end
    end

endmodule

// File: rtl/hhmm_display_scan.sv
// -----------------------------------------------------------------------------
// hhmm_display_scan
// Time-multiplexes the four BCD digits HH:MM onto one common-anode 7-segment
// bank. All four digits are snapshotted together when a new scan frame starts,
// so a count change never tears within a frame. Each digit slot opens with a
// GUARD-cycle blanking interval (all anodes off) to suppress ghosting, and the
// hours-tens leading zero is blanked. The colon is the dp of the hours-ones
// digit.
//
// Optional build macro DISP_COLON_BLINK_EN: when defined, the colon blinks
// with a half-period of BLINK_DIV clocks; otherwise it is steadily lit.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   GUARD        blanked cycles at the start of each slot (< REFRESH_DIV)
//   BLINK_DIV    clk cycles per colon half-period (blink builds only)
// Ports:
//   clk         in         system clock, rising edge
//   reset_n     in         synchronous active-low reset
//   hours_ones  in  [3:0]  BCD hours ones
//   hours_tens  in  [3:0]  BCD hours tens
//   min_ones    in  [3:0]  BCD minutes ones
//   min_tens    in  [3:0]  BCD minutes tens
//   seg         out [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp          out        decimal point / colon, active-low
//   an          out [3:0]  anode enables, active-low; an[0]=min_ones..an[3]=hours_tens
// -----------------------------------------------------------------------------
module hhmm_display_scan
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] hours_ones,
    input  logic [3:0] hours_tens,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int                CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_GUARD = CNT_W'(GUARD);
    // An illegal configuration keeps the bank dark instead of scanning garbage.
    localparam bit                CFG_OK    = (REFRESH_DIV >= 2) && (GUARD < REFRESH_DIV)
                                              && (BLINK_DIV >= 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  snap_q, snap_d;   // [idx] -> digit, same order as the anodes
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             slot_end;
    logic             frame_end;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    logic             colon_on;

`ifdef DISP_COLON_BLINK_EN
    localparam int               BLK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    assign colon_on = phase_q;
`else
    assign colon_on = 1'b1;
`endif

    assign cur_digit = snap_q[idx_q];

    bcd_to_seg u_bcd_to_seg (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == DIG_HR_TENS);

        cnt_d  = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d  = slot_end ? idx_q + 2'd1 : idx_q;
        snap_d = frame_end ? {hours_tens, hours_ones, min_tens, min_ones} : snap_q;

        // Outputs are built from the pre-edge state, so they trail cnt/idx by one clock.
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (CFG_OK && (cnt_q >= CNT_GUARD)) begin
            an_d[idx_q] = 1'b0;
            seg_d       = cur_seg;
            // Leading-zero blank keeps the anode on so slot brightness stays uniform.
            if ((idx_q == DIG_HR_TENS) && (cur_digit == 4'd0)) begin
                seg_d = SEG_BLANK;
            end
            dp_d = !((idx_q == DIG_HR_ONES) && colon_on);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

`ifdef DISP_COLON_BLINK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_hhmm_display_scan.sv
// -----------------------------------------------------------------------------
// tb_hhmm_display_scan
// Bench for hhmm_display_scan with REFRESH_DIV=4, GUARD=1, BLINK_DIV=8.
// The reference model tracks only the number of clocks since reset release and
// the frame snapshot; slot, position and colon phase are derived arithmetically,
// and digit patterns are built from the lit-segment letters of each numeral.
// -----------------------------------------------------------------------------
module tb_hhmm_display_scan;

    localparam int R     = 4;
    localparam int G     = 1;
    localparam int B     = 8;
    localparam int FRAME = 4 * R;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] hours_ones = 4'd0;
    logic [3:0] hours_tens = 4'd0;
    logic [3:0] min_ones = 4'd0;
    logic [3:0] min_tens = 4'd0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    hhmm_display_scan #(
        .REFRESH_DIV (R),
        .GUARD       (G),
        .BLINK_DIV   (B)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hours_ones (hours_ones),
        .hours_tens (hours_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: k = clocks since reset release, msnap = digits of the current frame.
    int k = 0;
    int msnap[4] = '{0, 0, 0, 0};

    // Expectations for the outputs visible after the most recent tick.
    int         exp_k;
    int         exp_idx;
    int         exp_cnt;
    bit         exp_guard;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    string lit[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] pattern(input int v);
        logic [6:0] p;
        int         b;
        if (v > 9) return 7'h3F;
        p = 7'h7F;
        for (int i = 0; i < lit[v].len(); i++) begin
            b = int'(lit[v][i]) - 97;
            p[b] = 1'b0;
        end
        return p;
    endfunction

    // Predict what the next rising edge publishes, advance the model, take the edge.
    task automatic tick();
        if (!reset_n) begin
            exp_k     = -1;
            exp_idx   = -1;
            exp_cnt   = -1;
            exp_guard = 1'b1;
            exp_an    = 4'b1111;
            exp_seg   = 7'h7F;
            exp_dp    = 1'b1;
            k         = 0;
            msnap     = '{0, 0, 0, 0};
        end else begin
            exp_k     = k;
            exp_cnt   = k % R;
            exp_idx   = (k / R) % 4;
            exp_guard = (exp_cnt < G);
            exp_an    = 4'b1111;
            exp_seg   = 7'h7F;
            exp_dp    = 1'b1;
            if (!exp_guard) begin
                exp_an[exp_idx] = 1'b0;
                exp_seg = (exp_idx == 3 && msnap[3] == 0) ? 7'h7F : pattern(msnap[exp_idx]);
                if (exp_idx == 2) begin
`ifdef DISP_COLON_BLINK_EN
                    exp_dp = (((k / B) % 2) == 1) ? 1'b0 : 1'b1;
`else
                    exp_dp = 1'b0;
`endif
                end
            end
            if (k % FRAME == FRAME - 1) begin
                msnap = '{int'(min_ones), int'(min_tens), int'(hours_ones), int'(hours_tens)};
            end
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        hours_tens = 4'd1;
        hours_ones = 4'd2;
        min_tens   = 4'd3;
        min_ones   = 4'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
                n_err++;
                $display("FAIL reset cyc=%0d an/seg/dp got %b/%h/%b want 1111/7f/1", i, an, seg, dp);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_scan_frames();
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL scan k=%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         exp_k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (i == 1) begin
                n_cmp++;
                if ({an, seg} !== {4'b1110, 7'h40}) begin
                    n_err++;
                    $display("FAIL scan_first_digit an/seg got %b/%h want 1110/40", an, seg);
                end
            end
            if (exp_k >= FRAME && !exp_guard) begin
                n_cmp++;
                if (seg !== pattern(4 - exp_idx)) begin
                    n_err++;
                    $display("FAIL scan_frame2 idx=%0d seg got %h want %h", exp_idx, seg, pattern(4 - exp_idx));
                end
            end
            if (exp_k < FRAME && exp_idx == 3 && !exp_guard) begin
                n_cmp++;
                if ({an, seg} !== {4'b0111, 7'h7F}) begin
                    n_err++;
                    $display("FAIL scan_frame1_lz an/seg got %b/%h want 0111/7f", an, seg);
                end
            end
        end
    endtask

    task automatic test_leading_zero();
        hours_tens = 4'd0;
        hours_ones = 4'd7;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL leading_zero k=%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         exp_k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (i >= 2 * FRAME && !exp_guard && exp_idx == 3) begin
                n_cmp++;
                if ({an, seg} !== {4'b0111, 7'h7F}) begin
                    n_err++;
                    $display("FAIL lz_blank an/seg got %b/%h want 0111/7f", an, seg);
                end
            end
            if (i >= 2 * FRAME && !exp_guard && exp_idx == 2) begin
                n_cmp++;
                if (seg !== 7'h78) begin
                    n_err++;
                    $display("FAIL lz_hours_ones seg got %h want 78", seg);
                end
`ifndef DISP_COLON_BLINK_EN
                n_cmp++;
                if (dp !== 1'b0) begin
                    n_err++;
                    $display("FAIL colon_steady dp got %b want 0", dp);
                end
`endif
            end
        end
    endtask

    task automatic test_mid_frame_change();
        int  change_k;
        int  next_frame;
        bit  changed;
        logic [6:0] want;
        min_ones = 4'd5;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL mid_change_warm k=%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         exp_k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
        changed  = 1'b0;
        change_k = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (!changed && (k % FRAME) == R + 2) begin
                min_ones = 4'd6;
                changed  = 1'b1;
                change_k = k;
            end
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL mid_change k=%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         exp_k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (!exp_guard && exp_idx == 0) begin
                next_frame = (change_k / FRAME + 1) * FRAME;
                want = (changed && exp_k >= next_frame) ? 7'h02 : 7'h12;
                n_cmp++;
                if (seg !== want) begin
                    n_err++;
                    $display("FAIL mid_change_min_ones k=%0d seg got %h want %h", exp_k, seg, want);
                end
            end
        end
        n_cmp++;
        if (!changed) begin
            n_err++;
            $display("FAIL mid_change_align changed got 0 want 1");
        end
    endtask

    task automatic test_dash();
        min_tens = 4'hB;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL dash k=%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         exp_k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (i >= 2 * FRAME && !exp_guard && exp_idx == 1) begin
                n_cmp++;
                if ({an, seg} !== {4'b1101, 7'h3F}) begin
                    n_err++;
                    $display("FAIL dash_slot an/seg got %b/%h want 1101/3f", an, seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        hours_tens = 4'd2;
        hours_ones = 4'd3;
        min_tens   = 4'd5;
        min_ones   = 4'd8;
        for (int i = 0; i < 3 * FRAME && (i < FRAME || (k % FRAME) != 2 * R + 3); i++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL rst_mid_warm k=%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         exp_k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
        n_cmp++;
        if ((k % FRAME) != 2 * R + 3) begin
            n_err++;
            $display("FAIL rst_mid_align pos got %0d want %0d", k % FRAME, 2 * R + 3);
        end
        reset_n = 1'b0;
        tick();
        n_cmp++;
        if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
            n_err++;
            $display("FAIL rst_mid_blank an/seg/dp got %b/%h/%b want 1111/7f/1", an, seg, dp);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL rst_mid k=%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         exp_k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (i == 0) begin
                n_cmp++;
                if (an !== 4'b1111) begin
                    n_err++;
                    $display("FAIL rst_mid_guard an got %b want 1111", an);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if ({an, seg} !== {4'b1110, 7'h40}) begin
                    n_err++;
                    $display("FAIL rst_mid_restart an/seg got %b/%h want 1110/40", an, seg);
                end
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 3);
                case (r)
                    0: min_ones   = 4'($urandom_range(0, 15));
                    1: min_tens   = 4'($urandom_range(0, 15));
                    2: hours_ones = 4'($urandom_range(0, 15));
                    default: hours_tens = 4'($urandom_range(0, 15));
                endcase
            end
            if (hours_tens > 4'd2 && $urandom_range(0, 1) == 0) hours_tens = 4'd0;
            reset_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                n_err++;
                $display("FAIL random k=%0d an/seg/dp got %b/%h/%b want %b/%h/%b",
                         exp_k, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (exp_idx != 2) begin
                n_cmp++;
                if (dp !== 1'b1) begin
                    n_err++;
                    $display("FAIL random_dp idx=%0d dp got %b want 1", exp_idx, dp);
                end
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan_frames();
        test_leading_zero();
        test_mid_frame_change();
        test_dash();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
